// File: rtl/word_capture_pkg.sv
// Shared types and constants for the word_capture block.
package word_capture_pkg;

  localparam int unsigned DROP_CNT_W = 16;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } state_e;

  // Number of narrow beats needed to replay one captured word.
  function automatic int unsigned beats_of(input int unsigned data_w, input int unsigned out_w);
    return data_w / out_w;
  endfunction

endpackage

// File: rtl/word_capture_if.sv
// Capture-side bus and beat stream of word_capture, grouped for port connection.
interface word_capture_if
  import word_capture_pkg::*;
#(
  parameter int unsigned DATA_W = 128,
  parameter int unsigned OUT_W  = 32,
  parameter int unsigned DEPTH  = 4
);
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  logic                  enable_i;
  logic                  clear_i;
  logic [DATA_W-1:0]     data_in_i;
  logic [OUT_W-1:0]      beat_data_o;
  logic                  beat_valid_o;
  logic                  beat_last_o;
  logic                  beat_ready_i;
  logic [CNT_W-1:0]      count_o;
  logic                  overflow_o;
  logic [DROP_CNT_W-1:0] drop_cnt_o;

  // Datapath / sink side: drives the monitored word and beat ready.
  modport master (
    output enable_i, clear_i, data_in_i, beat_ready_i,
    input  beat_data_o, beat_valid_o, beat_last_o, count_o, overflow_o, drop_cnt_o
  );

  // Capture block side.
  modport slave (
    input  enable_i, clear_i, data_in_i, beat_ready_i,
    output beat_data_o, beat_valid_o, beat_last_o, count_o, overflow_o, drop_cnt_o
  );

endinterface

// File: rtl/word_capture_fifo.sv
// Generic synchronous FIFO with wrap-bit pointers and a registered occupancy count.
module word_capture_fifo #(
  parameter int unsigned DATA_W = 128,
  parameter int unsigned DEPTH  = 4
) (
  input  logic                       clk_i,
  input  logic                       reset_i,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       flush,
  input  logic [DATA_W-1:0]          din,
  output logic [DATA_W-1:0]          dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PW-1:0]     wptr_q;
  logic [PW-1:0]     rptr_q;
  logic [PW-1:0]     count_q;
  logic              do_push;
  logic              do_pop;

  assign full    = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign empty   = (wptr_q == rptr_q);
  // A push into a full FIFO is still taken when the head leaves on the same edge.
  assign do_push = push && (!full || pop);
  assign do_pop  = pop && !empty;
  assign dout    = mem[rptr_q[AW-1:0]];
  assign count   = count_q;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else if (flush) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + PW'(1);
      if (do_pop)  rptr_q <= rptr_q + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + PW'(1);
        2'b01:   count_q <= count_q - PW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push && !flush) mem[wptr_q[AW-1:0]] <= din;
  end

endmodule

// File: rtl/word_capture.sv
// Change-detecting word capture with FIFO buffering and LSB-first narrow beat replay.
// Optional feature: WORD_CAPTURE_DROP_CNT_EN enables the saturating dropped-word counter.
module word_capture
  import word_capture_pkg::*;
#(
  parameter int unsigned DATA_W = 128,
  parameter int unsigned OUT_W  = 32,
  parameter int unsigned DEPTH  = 4
) (
  input  logic          clk_i,
  input  logic          reset_i,
  word_capture_if.slave bus
);

  localparam int unsigned BEATS  = beats_of(DATA_W, OUT_W);
  localparam int unsigned BCNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int unsigned CNT_W  = $clog2(DEPTH) + 1;

  state_e              state_q;
  state_e              state_d;
  logic [DATA_W-1:0]   prev_q;
  logic [DATA_W-1:0]   shreg_q;
  logic [DATA_W-1:0]   shreg_d;
  logic [DATA_W-1:0]   fifo_head;
  logic [BCNT_W-1:0]   bcnt_q;
  logic [BCNT_W-1:0]   bcnt_d;
  logic                last_q;
  logic                last_d;
  logic                overflow_q;
  logic                push_c;
  logic                pop_c;
  logic                drop_c;
  logic                fifo_full;
  logic                fifo_empty;
  logic [CNT_W-1:0]    fifo_count;

  assign push_c = bus.enable_i && !bus.clear_i && (bus.data_in_i != prev_q);
  assign drop_c = push_c && fifo_full && !pop_c;

  word_capture_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .push    (push_c),
    .pop     (pop_c),
    .flush   (bus.clear_i),
    .din     (bus.data_in_i),
    .dout    (fifo_head),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  // Last sampled word; tracked even when the word itself is dropped.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      prev_q     <= '0;
      overflow_q <= 1'b0;
    end else if (bus.clear_i) begin
      prev_q     <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (bus.enable_i) prev_q <= bus.data_in_i;
      if (drop_c)       overflow_q <= 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= ST_IDLE;
      shreg_q <= '0;
      bcnt_q  <= '0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      bcnt_q  <= bcnt_d;
      last_q  <= last_d;
    end
  end

  // Replay FSM; a head load on the final accepted beat keeps words back-to-back.
  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    bcnt_d  = bcnt_q;
    last_d  = last_q;
    pop_c   = 1'b0;
    if (bus.clear_i) begin
      state_d = ST_IDLE;
      shreg_d = '0;
      bcnt_d  = '0;
      last_d  = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: pop_c = !fifo_empty;
        ST_SEND: begin
          if (bus.beat_ready_i) begin
            if (last_q) begin
              pop_c   = !fifo_empty;
              state_d = ST_IDLE;
              shreg_d = '0;
              bcnt_d  = '0;
              last_d  = 1'b0;
            end else begin
              shreg_d = shreg_q >> OUT_W;
              bcnt_d  = bcnt_q + BCNT_W'(1);
              last_d  = (bcnt_d == BCNT_W'(BEATS - 1));
            end
          end
        end
      endcase
      if (pop_c) begin
        state_d = ST_SEND;
        shreg_d = fifo_head;
        bcnt_d  = '0;
        last_d  = (BEATS == 1);
      end
    end
  end

  assign bus.beat_valid_o = (state_q == ST_SEND);
  assign bus.beat_data_o  = shreg_q[OUT_W-1:0];
  assign bus.beat_last_o  = last_q;
  assign bus.count_o      = fifo_count;
  assign bus.overflow_o   = overflow_q;

`ifdef WORD_CAPTURE_DROP_CNT_EN
  logic [DROP_CNT_W-1:0] drop_cnt_q;

  // Saturating count of words lost to a full FIFO.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      drop_cnt_q <= '0;
    end else if (bus.clear_i) begin
      drop_cnt_q <= '0;
    end else if (drop_c && (drop_cnt_q != {DROP_CNT_W{1'b1}})) begin
      drop_cnt_q <= drop_cnt_q + DROP_CNT_W'(1);
    end
  end

  assign bus.drop_cnt_o = drop_cnt_q;
`else
  assign bus.drop_cnt_o = '0;
`endif

endmodule
